// File: rtl/pwm_capture.sv
// ----------------------------------------------------------------------------
// pwm_capture: measures high time and period of an external PWM input.
// Optional 3-sample glitch filter: PWM_CAPTURE_FILTER_EN.      Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pwm_capture #(
  parameter int CNT_BITS = 16
) (
  input  logic       clk_i,
  input  logic       nrst_i,
  input  logic       pwm_i,
  input  logic [7:0] b_addr_i,
  input  logic [7:0] b_data_i,
  input  logic       b_write_i,
  output logic [7:0] b_data_o,
  output logic       irq_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_HIGH = 2'd2,
    S_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_BITS-1:0] c_cnt_max = '1;

  state_t                r_state, w_state_nxt;
  logic                  r_sync1, r_sync2, r_level_d;
  logic                  w_level, w_rise, w_fall;
  logic                  r_en, r_ie, r_irq;
  logic [1:0]            r_ps;
  logic                  r_valid, r_ovf, r_miss;
  logic [CNT_BITS-1:0]   r_cnt, r_shadow, r_high, r_period, w_cnt_next;
  logic [5:0]            r_ps_cnt, w_div_m1;
  logic                  w_tick, w_ovf_hit;
  logic                  w_clr, w_run, w_latch, w_capture, w_ovf_set;
  logic                  w_ctl_wr, w_stat_wr, w_valid_eff, w_valid_nxt, w_ie_nxt;
  logic [2:0]            w_w1c;
  logic [15:0]           w_high16, w_period16;
  logic                  w_unused;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pwm_i;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  logic [1:0] r_hist;
  logic       r_filt;

  // Level follows the input only once three consecutive samples agree.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_hist <= 2'b00;
      r_filt <= 1'b0;
    end else begin
      r_hist <= {r_hist[0], r_sync2};
      if (r_hist[1] == r_sync2 && r_hist[0] == r_sync2)
        r_filt <= r_sync2;
    end
  end
  assign w_level = r_filt;
`else
  assign w_level = r_sync2;
`endif

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) r_level_d <= 1'b0;
    else         r_level_d <= w_level;
  end

  assign w_rise = w_level & ~r_level_d;
  assign w_fall = ~w_level & r_level_d;

  always_comb begin
    case (r_ps)
      2'd0:    w_div_m1 = 6'd0;
      2'd1:    w_div_m1 = 6'd3;
      2'd2:    w_div_m1 = 6'd15;
      default: w_div_m1 = 6'd63;
    endcase
  end

  // Count including the current cycle's tick, so latched values equal floor(dt/div).
  assign w_tick     = (r_ps_cnt == w_div_m1);
  assign w_cnt_next = r_cnt + CNT_BITS'(w_tick);
  assign w_ovf_hit  = (w_cnt_next == c_cnt_max);

  assign w_ctl_wr  = b_write_i && (b_addr_i == 8'h00);
  assign w_stat_wr = b_write_i && (b_addr_i == 8'h01);

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_run       = 1'b0;
    w_latch     = 1'b0;
    w_capture   = 1'b0;
    w_ovf_set   = 1'b0;
    case (r_state)
      S_IDLE: w_clr = 1'b1;
      S_ARM: begin
        if (w_rise) begin
          w_clr       = 1'b1;
          w_state_nxt = S_HIGH;
        end
      end
      S_HIGH: begin
        if (w_ovf_hit) begin
          w_ovf_set   = 1'b1;
          w_state_nxt = S_ARM;
        end else begin
          w_run = 1'b1;
          if (w_fall) begin
            w_latch     = 1'b1;
            w_state_nxt = S_LOW;
          end
        end
      end
      S_LOW: begin
        if (w_ovf_hit) begin
          w_ovf_set   = 1'b1;
          w_state_nxt = S_ARM;
        end else if (w_rise) begin
          w_capture   = 1'b1;
          w_clr       = 1'b1;
          w_state_nxt = S_HIGH;
        end else begin
          w_run = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Control writes override the measurement sequence.
    if (w_ctl_wr) begin
      if (!b_data_i[7])
        w_state_nxt = S_IDLE;
      else if (!r_en || (b_data_i[1:0] != r_ps))
        w_state_nxt = S_ARM;
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_cnt    <= '0;
      r_ps_cnt <= 6'd0;
      r_shadow <= '0;
    end else begin
      if (w_clr) begin
        r_cnt    <= '0;
        r_ps_cnt <= 6'd0;
      end else if (w_run) begin
        r_cnt    <= w_cnt_next;
        r_ps_cnt <= w_tick ? 6'd0 : r_ps_cnt + 6'd1;
      end
      if (w_latch)
        r_shadow <= w_cnt_next;
    end
  end

  // A capture landing with a W1C of VALID sees VALID as already cleared.
  assign w_w1c       = w_stat_wr ? b_data_i[2:0] : 3'b000;
  assign w_valid_eff = r_valid & ~w_w1c[0];
  assign w_valid_nxt = w_valid_eff | w_capture;
  assign w_ie_nxt    = w_ctl_wr ? b_data_i[6] : r_ie;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_en     <= 1'b0;
      r_ie     <= 1'b0;
      r_ps     <= 2'd0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
      r_miss   <= 1'b0;
      r_high   <= '0;
      r_period <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (w_ctl_wr) begin
        r_en <= b_data_i[7];
        r_ie <= b_data_i[6];
        r_ps <= b_data_i[1:0];
      end
      r_valid <= w_valid_nxt;
      r_ovf   <= (r_ovf & ~w_w1c[1]) | w_ovf_set;
      r_miss  <= (r_miss & ~w_w1c[2]) | (w_capture & w_valid_eff);
      if (w_capture && !w_valid_eff) begin
        r_high   <= r_shadow;
        r_period <= w_cnt_next;
      end
      r_irq <= w_valid_nxt & w_ie_nxt;
    end
  end

  assign irq_o      = r_irq;
  assign w_high16   = 16'(r_high);
  assign w_period16 = 16'(r_period);

  always_comb begin
    b_data_o = 8'h00;
    case (b_addr_i)
      8'h00: b_data_o = {r_en, r_ie, 4'b0000, r_ps};
      8'h01: b_data_o = {4'b0000, w_level, r_miss, r_ovf, r_valid};
      8'h02: b_data_o = w_high16[15:8];
      8'h03: b_data_o = w_high16[7:0];
      8'h04: b_data_o = w_period16[15:8];
      8'h05: b_data_o = w_period16[7:0];
      default: b_data_o = 8'h00;
    endcase
  end

  assign w_unused = ^b_data_i[5:3];

endmodule

`default_nettype wire

// File: tb/tb_pwm_capture.sv
// ----------------------------------------------------------------------------
// tb_pwm_capture: directed and randomized checks of pwm_capture.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pwm_capture;

  logic       clk_i = 1'b0;
  logic       nrst_i;
  logic       pwm_i;
  logic [7:0] b_addr_i, b_data_i, b_data_o;
  logic       b_write_i;
  logic       irq_o;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int rises[$];
  int falls[$];

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int c_lat = 5;
`else
  localparam int c_lat = 2;
`endif

  always #50 clk_i = ~clk_i;

  pwm_capture #(.CNT_BITS(16)) dut (
    .clk_i     (clk_i),
    .nrst_i    (nrst_i),
    .pwm_i     (pwm_i),
    .b_addr_i  (b_addr_i),
    .b_data_i  (b_data_i),
    .b_write_i (b_write_i),
    .b_data_o  (b_data_o),
    .irq_o     (irq_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Hold the input at lvl for n clocks; edge times feed the reference model.
  task automatic phase(input logic lvl, input int n);
    if (lvl !== pwm_i) begin
      if (lvl) rises.push_back(cyc);
      else     falls.push_back(cyc);
    end
    pwm_i = lvl;
    repeat (n) @(negedge clk_i);
    cyc += n;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    b_addr_i  = a;
    b_data_i  = d;
    b_write_i = 1'b1;
    @(negedge clk_i);
    b_write_i = 1'b0;
    cyc += 1;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    b_addr_i = a;
    #1;
    d = b_data_o;
  endtask

  task automatic rd16(input logic [7:0] a, output logic [15:0] d);
    logic [7:0] hi, lo;
    rd(a, hi);
    rd(a + 8'd1, lo);
    d = {hi, lo};
  endtask

  task automatic check_res(input string tag, input int h, input int p);
    logic [15:0] v;
    rd16(8'h02, v);
    check({tag, "_high"}, 32'(v), h);
    rd16(8'h04, v);
    check({tag, "_period"}, 32'(v), p);
  endtask

  task automatic check_stat(input string tag, input int valid, input int ovf, input int miss);
    logic [7:0] d;
    rd(8'h01, d);
    check({tag, "_valid"}, 32'(d[0]), valid);
    check({tag, "_ovf"},   32'(d[1]), ovf);
    check({tag, "_miss"},  32'(d[2]), miss);
  endtask

  initial begin
    logic [7:0]  d;
    logic [15:0] v;
    int          ps, div, ie, h1, l1, h2, l2;

    nrst_i = 1'b0; pwm_i = 1'b0;
    b_addr_i = 8'h00; b_data_i = 8'h00; b_write_i = 1'b0;
    repeat (3) @(negedge clk_i);
    nrst_i = 1'b1;
    @(negedge clk_i);

    // Reset values
    rd(8'h00, d);  check("rst_ctl0", 32'(d), 0);
    rd(8'h01, d);  check("rst_stat", 32'(d), 0);
    check_res("rst", 0, 0);
    rd(8'h07, d);  check("rst_unmapped", 32'(d), 0);
    check("rst_irq", 32'(irq_o), 0);

    // 300 high / 1000 period at divide-by-1
    wr(8'h00, 8'h80);
    rd(8'h00, d);  check("ctl0_rb", 32'(d), 32'h80);
    phase(0, 10);
    phase(1, 300); phase(0, 700); phase(1, 10);
    check_stat("cap1", 1, 0, 0);
    check_res("cap1", 300, 1000);
    phase(1, 290); phase(0, 700); phase(1, 300); phase(0, 700); phase(1, 10);
    check_stat("miss1", 1, 0, 1);
    check_res("miss1", 300, 1000);

    // Divide-by-16 with interrupt enable
    wr(8'h00, 8'hC2);
    check("irq_ie_on", 32'(irq_o), 1);
    wr(8'h01, 8'h07);
    check("irq_w1c", 32'(irq_o), 0);
    check_stat("w1c", 0, 0, 0);
    phase(0, 700); phase(1, 300); phase(0, 700); phase(1, 10);
    check("irq_cap2", 32'(irq_o), 1);
    check_res("cap2", 18, 62);
    wr(8'h01, 8'h07);
    check("irq_drop", 32'(irq_o), 0);
    phase(1, 289); phase(0, 700); phase(1, 10);
    check("irq_cap3", 32'(irq_o), 1);
    check_res("cap3", 18, 62);

    // Input stuck high after a rise: overflow, then return to ARM
    wr(8'h00, 8'h00);
    phase(0, 10);
    wr(8'h01, 8'h07);
    wr(8'h00, 8'h80);
    phase(0, 5);
    phase(1, 65000);
    check_stat("pre_ovf", 0, 0, 0);
    phase(1, 600);
    check_stat("ovf", 0, 1, 0);
    check("ovf_irq", 32'(irq_o), 0);
    phase(0, 50); phase(1, 40); phase(0, 60); phase(1, 10);
    check_stat("after_ovf", 1, 1, 0);
    check_res("after_ovf", 40, 100);

    // W1C of VALID in the capturing cycle: capture wins
    phase(1, 40); phase(0, 80);
    phase(1, c_lat);
    wr(8'h01, 8'h01);
    phase(1, 10);
    check_stat("w1c_race", 1, 1, 0);
    check_res("w1c_race", 50, 130);

    // Asynchronous reset in the middle of HIGH
    phase(1, 5);
    nrst_i = 1'b0;
    rd(8'h00, d);  check("mid_rst_ctl0", 32'(d), 0);
    rd(8'h01, d);  check("mid_rst_stat", 32'(d), 0);
    check_res("mid_rst", 0, 0);
    check("mid_rst_irq", 32'(irq_o), 0);
    repeat (3) @(negedge clk_i);
    cyc += 3;
    nrst_i = 1'b1;
    phase(0, 10);
    wr(8'h00, 8'h80);
    phase(0, 5);
    phase(1, 123); phase(0, 77); phase(1, 10);
    check_stat("post_rst", 1, 0, 0);
    check_res("post_rst", 123, 200);

    // 2-clock glitches on a low input
    wr(8'h00, 8'h00);
    phase(0, 10);
    wr(8'h01, 8'h07);
    wr(8'h00, 8'h80);
    phase(0, 5);
    for (int g = 0; g < 3; g++) begin
      phase(1, 2);
      rd(8'h01, d);
`ifdef PWM_CAPTURE_FILTER_EN
      check("glitch_level", 32'(d[3]), 0);
`else
      check("glitch_level", 32'(d[3]), 1);
`endif
      phase(0, 18);
    end
`ifdef PWM_CAPTURE_FILTER_EN
    rd(8'h01, d);  check("glitch_stat", 32'(d), 0);
`else
    check_stat("glitch", 1, 0, 1);
    check_res("glitch", 2, 20);
`endif

    // Randomized cycles against the edge-time model
    for (int t = 0; t < 6; t++) begin
      wr(8'h00, 8'h00);
      wr(8'h01, 8'h07);
      phase(0, 8);
      ps  = $urandom_range(0, 3);
      ie  = $urandom_range(0, 1);
      div = 1 << (2 * ps);
      wr(8'h00, 8'h80 | 8'(ie << 6) | 8'(ps));
      phase(0, 5);
      rises.delete();
      falls.delete();
      h1 = $urandom_range(3, 300); l1 = $urandom_range(3, 300);
      h2 = $urandom_range(3, 300); l2 = $urandom_range(3, 300);
      phase(1, h1); phase(0, l1); phase(1, h2); phase(0, l2); phase(1, 8);
      check_stat("rnd", 1, 0, (rises.size() >= 3) ? 1 : 0);
      check_res("rnd", (falls[0] - rises[0]) / div, (rises[1] - rises[0]) / div);
      check("rnd_irq", 32'(irq_o), ie);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
